// File: rtl/ifetch_router_pkg.sv
// rtl/ifetch_router_pkg.sv - shared limits and types for the instruction-fetch router
// Purpose: upper bounds on region count and in-flight depth, plus the
//          region-index type (one extra code for the unmapped/error target)
//          and the outstanding-counter type.
package ifetch_router_pkg;

  localparam int MaxRegions = 8;
  localparam int MaxOut     = 4;

  localparam int IdxWidth = $clog2(MaxRegions + 1);
  localparam int CntWidth = $clog2(MaxOut + 1);

  typedef logic [IdxWidth-1:0] region_idx_t;
  typedef logic [CntWidth-1:0] cnt_t;

endpackage

// File: rtl/ifetch_addr_decode.sv
// rtl/ifetch_addr_decode.sv - priority base/mask address decoder
// Purpose: picks the lowest-index region whose masked address equals its base.
//          When nothing matches, sel_o = NrRegions (the error target).
// Ports:
//   addr_i  : address to decode
//   base_i  : per-region base addresses
//   mask_i  : per-region address masks
//   sel_o   : selected region index, or NrRegions when unmapped
module ifetch_addr_decode
  import ifetch_router_pkg::*;
#(
  parameter int NrRegions = 2,
  parameter int AddrWidth = 32
) (
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [NrRegions-1:0][AddrWidth-1:0] base_i,
  input  logic [NrRegions-1:0][AddrWidth-1:0] mask_i,
  output region_idx_t                         sel_o
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    sel_o = region_idx_t'(NrRegions);
    for (int r = NrRegions - 1; r >= 0; r--) begin
      if ((addr_i & mask_i[r]) == base_i[r]) begin
        sel_o = region_idx_t'(r);
      end
    end
  end

endmodule

// File: rtl/ifetch_router.sv
// rtl/ifetch_router.sv - in-order instruction-fetch router over NrRegions memories
// Purpose: decodes each fetch, forwards it to one region, tracks up to
//          MaxOutstanding in-flight fetches, and returns responses in order.
//          Unmapped fetches complete with an error response one cycle after grant.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   host_req_i/addr_i      : fetch request and address from the core
//   host_gnt_o             : fetch accepted this cycle
//   host_rvalid_o/rdata_o  : response valid and data
//   host_err_o             : response is an error (qualified by rvalid)
//   cfg_region_base/mask_i : per-region decode configuration
//   region_req_o/addr_o    : per-region request, broadcast address
//   region_gnt_i           : per-region grant
//   region_rvalid/rdata/err_i : per-region response
module ifetch_router
  import ifetch_router_pkg::*;
#(
  parameter int NrRegions      = 2,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                host_req_i,
  input  logic [AddrWidth-1:0]                host_addr_i,
  output logic                                host_gnt_o,
  output logic                                host_rvalid_o,
  output logic [DataWidth-1:0]                host_rdata_o,
  output logic                                host_err_o,
  input  logic [NrRegions-1:0][AddrWidth-1:0] cfg_region_base_i,
  input  logic [NrRegions-1:0][AddrWidth-1:0] cfg_region_mask_i,
  output logic [NrRegions-1:0]                region_req_o,
  output logic [AddrWidth-1:0]                region_addr_o,
  input  logic [NrRegions-1:0]                region_gnt_i,
  input  logic [NrRegions-1:0]                region_rvalid_i,
  input  logic [NrRegions-1:0][DataWidth-1:0] region_rdata_i,
  input  logic [NrRegions-1:0]                region_err_i
);

  localparam region_idx_t ErrIdx = region_idx_t'(NrRegions);
  localparam cnt_t        CntMax = cnt_t'(MaxOutstanding);

  region_idx_t sel;
  region_idx_t cur_q, cur_d;
  cnt_t        cnt_q, cnt_d;
  logic        err_pend_q, err_pend_d;
  logic        mapped, can_issue, issue;

  ifetch_addr_decode #(
    .NrRegions(NrRegions),
    .AddrWidth(AddrWidth)
  ) u_decode (
    .addr_i(host_addr_i),
    .base_i(cfg_region_base_i),
    .mask_i(cfg_region_mask_i),
    .sel_o (sel)
  );

  assign region_addr_o = host_addr_i;
  assign mapped        = (sel != ErrIdx);

  // Switching target waits for a full drain so responses cannot reorder.
  // cnt_q is the registered count: a response this cycle frees no slot yet.
  assign can_issue = (cnt_q < CntMax) && ((cnt_q == '0) || (sel == cur_q));
  assign issue     = host_req_i && can_issue;

  always_comb begin
    region_req_o = '0;
    host_gnt_o   = 1'b0;
    if (!mapped) begin
      host_gnt_o = issue;
    end else begin
      for (int r = 0; r < NrRegions; r++) begin
        if (sel == region_idx_t'(r)) begin
          region_req_o[r] = issue;
          host_gnt_o      = issue && region_gnt_i[r];
        end
      end
    end
  end

  // Only the current target may complete a fetch; anything else is ignored.
  always_comb begin
    host_rvalid_o = 1'b0;
    host_err_o    = 1'b0;
    host_rdata_o  = '0;
    if (cnt_q != '0) begin
      if (cur_q == ErrIdx) begin
        host_rvalid_o = err_pend_q;
        host_err_o    = err_pend_q;
      end else begin
        for (int r = 0; r < NrRegions; r++) begin
          if ((cur_q == region_idx_t'(r)) && region_rvalid_i[r]) begin
            host_rvalid_o = 1'b1;
            host_rdata_o  = region_rdata_i[r];
            host_err_o    = region_err_i[r];
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    err_pend_d = err_pend_q;
    if (host_gnt_o) begin
      cur_d = sel;
    end
    case ({host_gnt_o, host_rvalid_o})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
    if (host_rvalid_o && (cur_q == ErrIdx)) begin
      err_pend_d = 1'b0;
    end
    // A new unmapped grant wins over a same-cycle error completion.
    if (host_gnt_o && !mapped) begin
      err_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      cur_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      err_pend_q <= err_pend_d;
    end
  end

endmodule

// File: tb/tb_ifetch_router.sv
// tb/tb_ifetch_router.sv - self-checking bench for ifetch_router
module tb_ifetch_router;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             host_req;
  logic [31:0]      host_addr;
  logic             gnt, rvalid, err;
  logic [31:0]      rdata;
  logic [1:0][31:0] base, mask;
  logic [1:0]       rreq;
  logic [31:0]      raddr;
  logic [1:0]       rgnt, rrv, rerr;
  logic [1:0][31:0] rrd;

  always #5 clk = ~clk;

  ifetch_router dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_addr_i(host_addr), .host_gnt_o(gnt),
    .host_rvalid_o(rvalid), .host_rdata_o(rdata), .host_err_o(err),
    .cfg_region_base_i(base), .cfg_region_mask_i(mask),
    .region_req_o(rreq), .region_addr_o(raddr), .region_gnt_i(rgnt),
    .region_rvalid_i(rrv), .region_rdata_i(rrd), .region_err_i(rerr)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Region memories: 1-cycle latency, answer from a FIFO when ready.
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  logic [1:0]  rdy;
  logic [1:0]  stale;

  function automatic logic [31:0] data_of(input int r, input logic [31:0] a);
    return a + (32'(r + 1) << 28);
  endfunction

  function automatic logic err_of(input int r, input logic [31:0] a);
    return (r == 1) && (a[11:0] == 12'h000);
  endfunction

  task automatic drive_regions();
    rrv  = stale;
    rrd  = '0;
    rerr = '0;
    if (stale[0]) rrd[0] = 32'hBAD0_0000;
    if (rq0.size() > 0 && rdy[0]) begin
      rrv[0] = 1'b1; rrd[0] = data_of(0, rq0[0]); rerr[0] = err_of(0, rq0[0]);
    end
    if (rq1.size() > 0 && rdy[1]) begin
      rrv[1] = 1'b1; rrd[1] = data_of(1, rq1[0]); rerr[1] = err_of(1, rq1[0]);
    end
  endtask

  task automatic advance();
    logic [1:0]  push, pop;
    logic [31:0] a;
    push = rreq & rgnt;
    pop  = rrv & ~stale;
    a    = raddr;
    @(posedge clk);
    #1;
    if (pop[0])  void'(rq0.pop_front());
    if (pop[1])  void'(rq1.pop_front());
    if (push[0]) rq0.push_back(a);
    if (push[1]) rq1.push_back(a);
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [1:0]  rdy;
    logic        gnt;
    logic [1:0]  rreq;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic q, input logic [31:0] a, input logic [1:0] rd,
                              input logic g, input logic [1:0] rr, input logic v,
                              input logic e, input logic [31:0] d);
    vec_t x;
    x.req = q; x.addr = a; x.rdy = rd; x.gnt = g; x.rreq = rr; x.rv = v; x.err = e; x.rdata = d;
    return x;
  endfunction

  typedef struct {
    int          tgt;
    logic [31:0] addr;
  } fl_t;

  function automatic int decode(input logic [31:0] a);
    for (int r = 0; r < 2; r++) if ((a & mask[r]) == base[r]) return r;
    return 2;
  endfunction

  vec_t vec[20];
  fl_t  inflight[$];

  initial begin
    base[0] = 32'h0010_0000; mask[0] = 32'hFFFF_0000;
    base[1] = 32'h1A11_0000; mask[1] = 32'hFFFF_0000;
    rst_n = 1'b0; host_req = 1'b0; host_addr = '0;
    rgnt = 2'b11; rdy = 2'b11; stale = 2'b00;
    drive_regions();

    vec[0]  = mk(1, 32'h0010_0080, 2'b11, 1, 2'b01, 0, 0, 32'h0);
    vec[1]  = mk(1, 32'h0010_0084, 2'b11, 1, 2'b01, 1, 0, 32'h1010_0080);
    vec[2]  = mk(1, 32'h0010_0088, 2'b11, 1, 2'b01, 1, 0, 32'h1010_0084);
    vec[3]  = mk(0, 32'h0,         2'b11, 0, 2'b00, 1, 0, 32'h1010_0088);
    vec[4]  = mk(1, 32'h0010_0100, 2'b11, 1, 2'b01, 0, 0, 32'h0);
    vec[5]  = mk(1, 32'h1A11_0800, 2'b11, 0, 2'b00, 1, 0, 32'h1010_0100);
    vec[6]  = mk(1, 32'h1A11_0800, 2'b11, 1, 2'b10, 0, 0, 32'h0);
    vec[7]  = mk(0, 32'h0,         2'b11, 0, 2'b00, 1, 0, 32'h3A11_0800);
    vec[8]  = mk(1, 32'h4000_0000, 2'b11, 1, 2'b00, 0, 0, 32'h0);
    vec[9]  = mk(0, 32'h0,         2'b11, 0, 2'b00, 1, 1, 32'h0);
    vec[10] = mk(1, 32'h0010_0200, 2'b10, 1, 2'b01, 0, 0, 32'h0);
    vec[11] = mk(1, 32'h0010_0204, 2'b10, 1, 2'b01, 0, 0, 32'h0);
    vec[12] = mk(1, 32'h0010_0208, 2'b10, 0, 2'b00, 0, 0, 32'h0);
    vec[13] = mk(1, 32'h0010_0208, 2'b10, 0, 2'b00, 0, 0, 32'h0);
    vec[14] = mk(1, 32'h0010_0208, 2'b10, 0, 2'b00, 0, 0, 32'h0);
    vec[15] = mk(1, 32'h0010_0208, 2'b11, 0, 2'b00, 1, 0, 32'h1010_0200);
    vec[16] = mk(1, 32'h0010_0208, 2'b11, 1, 2'b01, 1, 0, 32'h1010_0204);
    vec[17] = mk(0, 32'h0,         2'b11, 0, 2'b00, 1, 0, 32'h1010_0208);
    vec[18] = mk(1, 32'h1A11_0000, 2'b11, 1, 2'b10, 0, 0, 32'h0);
    vec[19] = mk(0, 32'h0,         2'b11, 0, 2'b00, 1, 1, 32'h3A11_0000);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst rreq", 32'(rreq), 32'h0);
    check("rst rvalid", 32'(rvalid), 32'h0);
    check("rst err", 32'(err), 32'h0);
    check("rst rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // Directed cycle table
    for (int i = 0; i < 20; i++) begin
      host_req = vec[i].req; host_addr = vec[i].addr; rdy = vec[i].rdy; rgnt = 2'b11;
      drive_regions();
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vec[i].gnt));
      check($sformatf("v%0d rreq", i), 32'(rreq), 32'(vec[i].rreq));
      check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vec[i].rv));
      check($sformatf("v%0d err", i), 32'(err), 32'(vec[i].err));
      check($sformatf("v%0d rdata", i), rdata, vec[i].rdata);
      advance();
    end

    // Reset with two fetches in flight, then a stale response
    rdy = 2'b00;
    for (int i = 0; i < 2; i++) begin
      host_req = 1'b1; host_addr = 32'h0010_0300 + 32'(4 * i);
      drive_regions();
      #1;
      check($sformatf("fill%0d gnt", i), 32'(gnt), 32'h1);
      advance();
    end
    host_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst gnt", 32'(gnt), 32'h0);
    check("midrst rreq", 32'(rreq), 32'h0);
    check("midrst rvalid", 32'(rvalid), 32'h0);
    check("midrst rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rq0.delete(); rq1.delete();
    rdy = 2'b11; stale = 2'b01;
    drive_regions();
    #1;
    check("stale rvalid", 32'(rvalid), 32'h0);
    check("stale rdata", rdata, 32'h0);
    advance();
    stale = 2'b00;
    host_req = 1'b1; host_addr = 32'h0010_0000;
    drive_regions();
    #1;
    check("postrst gnt", 32'(gnt), 32'h1);
    check("postrst rreq", 32'(rreq), 32'h1);
    check("postrst rvalid", 32'(rvalid), 32'h0);
    advance();
    host_req = 1'b0;
    drive_regions();
    #1;
    check("postrst resp", 32'(rvalid), 32'h1);
    check("postrst data", rdata, 32'h1010_0000);
    check("postrst err", 32'(err), 32'h0);
    advance();

    // Randomized traffic against an in-order reference queue
    begin
      logic       hold;
      int         s, t;
      logic       can, eg, erv;
      logic [1:0] erq;
      hold = 1'b0;
      inflight.delete();
      for (int c = 0; c < 400; c++) begin
        if (!hold) begin
          host_req = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 2))
            0:       host_addr = 32'h0010_0000 | ($urandom & 32'h0000_FFFC);
            1:       host_addr = 32'h1A11_0000 | ($urandom & 32'h0000_FFFC);
            default: host_addr = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
          endcase
        end
        rgnt = 2'($urandom);
        rdy  = 2'($urandom);
        drive_regions();
        #1;
        s   = decode(host_addr);
        can = (inflight.size() < 2) && ((inflight.size() == 0) || (inflight[0].tgt == s));
        eg  = host_req && can && ((s == 2) || rgnt[s]);
        erq = (host_req && can && s < 2) ? (2'b01 << s) : 2'b00;
        erv = 1'b0;
        t   = 0;
        if (inflight.size() > 0) begin
          t   = inflight[0].tgt;
          erv = (t == 2) ? 1'b1 : rdy[t];
        end
        check($sformatf("r%0d gnt", c), 32'(gnt), 32'(eg));
        check($sformatf("r%0d rreq", c), 32'(rreq), 32'(erq));
        check($sformatf("r%0d raddr", c), raddr, host_addr);
        check($sformatf("r%0d rvalid", c), 32'(rvalid), 32'(erv));
        if (erv) begin
          check($sformatf("r%0d rdata", c), rdata,
                (t == 2) ? 32'h0 : data_of(t, inflight[0].addr));
          check($sformatf("r%0d err", c), 32'(err),
                (t == 2) ? 32'h1 : 32'(err_of(t, inflight[0].addr)));
        end
        hold = host_req && !eg;
        if (erv) void'(inflight.pop_front());
        if (eg)  inflight.push_back('{s, host_addr});
        advance();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
